// File: rtl/issue_pkg.sv
// issue_pkg
//   Shared types and constants for the issue pair buffer.
//   ibuf_entry_t : one buffered instruction {pc, instr}
//   ILEN_BYTES   : byte size of one instruction; the second fetched
//                  instruction sits this far after the first.
package issue_pkg;

    localparam int IBUF_XLEN  = 32;
    localparam int IBUF_ILEN  = 32;
    localparam int ILEN_BYTES = 4;

    typedef struct packed {
        logic [IBUF_XLEN-1:0] pc;
        logic [IBUF_ILEN-1:0] instr;
    } ibuf_entry_t;

endpackage

// File: rtl/issue_pair_buffer.sv
// issue_pair_buffer
//   Circular instruction buffer between fetch and the dual-issue check.
//   Accepts 0-2 sequential instructions per cycle and presents the two
//   oldest entries as slot 0 / slot 1 candidates. 1 or 2 entries are
//   dequeued according to the returned issue decision.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         discard all buffered entries
//   stall                         no dequeue this cycle
//   fetch_valid[1:0]              bit0 instr0 valid, bit1 instr1 valid
//   fetch_pc, fetch_instr0/1      fetched pair (instr1 PC = fetch_pc + 4)
//   fetch_ready                   room for two entries (from registered count)
//   slot0_*/slot1_*               head / head+1 candidates
//   issue0, issue1                pairing decision for the presented pair
//   count                         occupancy
//
// Build option
//   ISSUE_PAIR_STATS_EN : adds dual_cnt, single_cnt, empty_cnt saturating
//                         32-bit event counters (not cleared by flush).
//
// Entry storage uses ibuf_entry_t, so XLEN/ILEN must match the package widths.
module issue_pair_buffer
    import issue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = IBUF_XLEN,
    parameter int ILEN  = IBUF_ILEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall,
    input  logic [1:0]             fetch_valid,
    input  logic [XLEN-1:0]        fetch_pc,
    input  logic [ILEN-1:0]        fetch_instr0,
    input  logic [ILEN-1:0]        fetch_instr1,
    output logic                   fetch_ready,
    output logic                   slot0_valid,
    output logic [XLEN-1:0]        slot0_pc,
    output logic [ILEN-1:0]        slot0_instr,
    output logic                   slot1_valid,
    output logic [XLEN-1:0]        slot1_pc,
    output logic [ILEN-1:0]        slot1_instr,
    input  logic                   issue0,
    input  logic                   issue1,
`ifdef ISSUE_PAIR_STATS_EN
    output logic [31:0]            dual_cnt,
    output logic [31:0]            single_cnt,
    output logic [31:0]            empty_cnt,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ibuf_entry_t   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_p1;
    logic [1:0]    enq;
    logic [1:0]    deq;

    assign head_p1     = head_q + AW'(1);
    assign count       = count_q;
    assign fetch_ready = (count_q <= CW'(DEPTH - 2));
    assign slot0_valid = (count_q >= CW'(1));
    assign slot1_valid = (count_q >= CW'(2));
    assign slot0_pc    = mem_q[head_q].pc;
    assign slot0_instr = mem_q[head_q].instr;
    assign slot1_pc    = mem_q[head_p1].pc;
    assign slot1_instr = mem_q[head_p1].instr;

    // fetch_valid = 2'b10 has no valid first instruction and enqueues nothing
    always_comb begin
        enq = 2'd0;
        if (fetch_ready && fetch_valid[0]) begin
            enq = fetch_valid[1] ? 2'd2 : 2'd1;
        end
    end

    // issue1 without a valid slot 1 collapses to a single dequeue
    always_comb begin
        deq = 2'd0;
        if (!stall && slot0_valid && issue0) begin
            deq = (issue1 && slot1_valid) ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        head_d  = head_q + AW'(deq);
        tail_d  = tail_q + AW'(enq);
        count_d = count_q + CW'(enq) - CW'(deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is cleared on reset so invalid slot outputs never show X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush && enq != 2'd0) begin
            mem_q[tail_q] <= '{pc: fetch_pc, instr: fetch_instr0};
            if (enq == 2'd2) begin
                mem_q[tail_q + AW'(1)] <= '{pc: fetch_pc + XLEN'(ILEN_BYTES),
                                           instr: fetch_instr1};
            end
        end
    end

`ifdef ISSUE_PAIR_STATS_EN
    logic [31:0] dual_cnt_q, single_cnt_q, empty_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dual_cnt_q   <= '0;
            single_cnt_q <= '0;
            empty_cnt_q  <= '0;
        end else begin
            if (deq == 2'd2 && dual_cnt_q != '1) begin
                dual_cnt_q <= dual_cnt_q + 32'd1;
            end
            if (deq == 2'd1 && single_cnt_q != '1) begin
                single_cnt_q <= single_cnt_q + 32'd1;
            end
            if (!slot0_valid && !stall && empty_cnt_q != '1) begin
                empty_cnt_q <= empty_cnt_q + 32'd1;
            end
        end
    end

    assign dual_cnt   = dual_cnt_q;
    assign single_cnt = single_cnt_q;
    assign empty_cnt  = empty_cnt_q;
`endif

endmodule

// File: tb/tb_issue_pair_buffer.sv
module tb_issue_pair_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  fetch_valid = 2'b00;
    logic [31:0] fetch_pc = '0;
    logic [31:0] fetch_instr0 = '0;
    logic [31:0] fetch_instr1 = '0;
    logic        fetch_ready;
    logic        slot0_valid, slot1_valid;
    logic [31:0] slot0_pc, slot0_instr, slot1_pc, slot1_instr;
    logic        issue0 = 1'b0;
    logic        issue1 = 1'b0;
    logic [3:0]  count;
`ifdef ISSUE_PAIR_STATS_EN
    logic [31:0] dual_cnt, single_cnt, empty_cnt;
`endif

    issue_pair_buffer #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .stall        (stall),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_instr0 (fetch_instr0),
        .fetch_instr1 (fetch_instr1),
        .fetch_ready  (fetch_ready),
        .slot0_valid  (slot0_valid),
        .slot0_pc     (slot0_pc),
        .slot0_instr  (slot0_instr),
        .slot1_valid  (slot1_valid),
        .slot1_pc     (slot1_pc),
        .slot1_instr  (slot1_instr),
        .issue0       (issue0),
        .issue1       (issue1),
`ifdef ISSUE_PAIR_STATS_EN
        .dual_cnt     (dual_cnt),
        .single_cnt   (single_cnt),
        .empty_cnt    (empty_cnt),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: program-ordered queue of {pc, instr}
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    longint      m_dual, m_single, m_empty;
    int          m_n, m_d;
    bit          m_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_dual = 0; m_single = 0; m_empty = 0;
        end else begin
            m_n   = mq.size();
            m_rdy = (DEPTH - m_n) >= 2;
            if (stall || m_n == 0 || !issue0) m_d = 0;
            else if (issue1 && m_n >= 2)      m_d = 2;
            else                               m_d = 1;
            if (m_d == 2) m_dual++;
            if (m_d == 1) m_single++;
            if (m_n == 0 && !stall) m_empty++;
            if (flush) mq.delete();
            else begin
                repeat (m_d) void'(mq.pop_front());
                if (m_rdy && fetch_valid[0]) begin
                    mq.push_back('{pc: fetch_pc, instr: fetch_instr0});
                    if (fetch_valid[1])
                        mq.push_back('{pc: fetch_pc + 32'd4, instr: fetch_instr1});
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("fetch_ready", 64'(fetch_ready), 64'((DEPTH - mq.size()) >= 2));
            chk("slot0_valid", 64'(slot0_valid), 64'(mq.size() >= 1));
            chk("slot1_valid", 64'(slot1_valid), 64'(mq.size() >= 2));
            if (mq.size() >= 1) begin
                chk("slot0_pc", 64'(slot0_pc), 64'(mq[0].pc));
                chk("slot0_instr", 64'(slot0_instr), 64'(mq[0].instr));
            end
            if (mq.size() >= 2) begin
                chk("slot1_pc", 64'(slot1_pc), 64'(mq[1].pc));
                chk("slot1_instr", 64'(slot1_instr), 64'(mq[1].instr));
            end
`ifdef ISSUE_PAIR_STATS_EN
            chk("dual_cnt", 64'(dual_cnt), 64'(m_dual));
            chk("single_cnt", 64'(single_cnt), 64'(m_single));
            chk("empty_cnt", 64'(empty_cnt), 64'(m_empty));
`endif
        end
    end

    // Drive one cycle of inputs after a negedge, return at the next negedge.
    task automatic step(input logic [1:0] fv, input logic [31:0] pc,
                        input logic is0, input logic is1,
                        input logic st, input logic fl);
        fetch_valid  = fv;
        fetch_pc     = pc;
        fetch_instr0 = $urandom;
        fetch_instr1 = $urandom;
        issue0       = is0;
        issue1       = is1;
        stall        = st;
        flush        = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] ia, ib;
    longint      dual_before;
    int          r;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_slot0_valid", 64'(slot0_valid), 64'd0);
        chk("rst_slot1_valid", 64'(slot1_valid), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        chk("rst_slot_not_x", 64'($isunknown({slot0_pc, slot0_instr, slot1_pc, slot1_instr})), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // pair enqueue, visible one cycle later
        ia = 32'hAAAA_0001; ib = 32'hBBBB_0002;
        fetch_valid = 2'b11; fetch_pc = 32'h100; fetch_instr0 = ia; fetch_instr1 = ib;
        issue0 = 1'b0; issue1 = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pair_slot0_pc", 64'(slot0_pc), 64'h100);
        chk("pair_slot0_instr", 64'(slot0_instr), 64'(ia));
        chk("pair_slot1_pc", 64'(slot1_pc), 64'h104);
        chk("pair_slot1_instr", 64'(slot1_instr), 64'(ib));
        chk("pair_count", 64'(count), 64'd2);

        // single issue: B moves to slot 0
        step(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_slot0_pc", 64'(slot0_pc), 64'h104);
        chk("single_slot0_instr", 64'(slot0_instr), 64'(ib));
        chk("single_slot1_valid", 64'(slot1_valid), 64'd0);
        chk("single_count", 64'(count), 64'd1);

        // fill to near full
        step(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2'b01, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h210, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h220, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h230, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_count7", 64'(count), 64'd7);
        chk("full_ready0", 64'(fetch_ready), 64'd0);
        step(2'b11, 32'h240, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_blocked_count", 64'(count), 64'd7);

        // wrap: place a pair at indices 7 and 0, walk head to 7
        step(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_count", 64'(count), 64'd2);
        chk("wrap_slot0_pc", 64'(slot0_pc), 64'h300);
        chk("wrap_slot1_pc", 64'(slot1_pc), 64'h304);
        step(2'b00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap_dual_count", 64'(count), 64'd0);
        step(2'b01, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_after_pc", 64'(slot0_pc), 64'h400);

        // flush beats same-cycle enqueue and dual issue
        step(2'b11, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h600, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_slot0_valid", 64'(slot0_valid), 64'd0);
        chk("flush_ready", 64'(fetch_ready), 64'd1);

        // stall holds head while a single enqueue lands
        step(2'b11, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h708, 1'b0, 1'b0, 1'b0, 1'b0);
        dual_before = m_dual;
        step(2'b01, 32'h710, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("stall_count", 64'(count), 64'd5);
        chk("stall_slot0_pc", 64'(slot0_pc), 64'h700);
        chk("stall_slot1_pc", 64'(slot1_pc), 64'h704);
`ifdef ISSUE_PAIR_STATS_EN
        chk("stall_dual_cnt", 64'(dual_cnt), 64'(dual_before));
`endif

        // illegal fetch_valid enqueues nothing
        step(2'b10, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fv10_count", 64'(count), 64'd5);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] fv;
            r = $urandom_range(0, 99);
            if (r < 5) fv = 2'b10;
            else if (r < 30) fv = 2'b00;
            else if (r < 60) fv = 2'b01;
            else fv = 2'b11;
            step(fv, $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3));
        end

        // asynchronous reset in the middle of a cycle
        step(2'b11, 32'h900, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_valid", 64'(slot0_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(2'b11, 32'hA00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_count", 64'(count), 64'd2);
        chk("post_rst_pc", 64'(slot0_pc), 64'hA00);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
